// File: rtl/div_arbiter_if.sv
// Requester and divider-side signals for div_arbiter.
// master: the arbiter. slave: the requesters and the divider.
interface div_arbiter_if #(
  parameter int unsigned WIDTH = 12
);
  logic             req_s;
  logic [WIDTH-1:0] dividend_s;
  logic [WIDTH-1:0] divisor_s;
  logic             req_a;
  logic [WIDTH-1:0] dividend_a;
  logic [WIDTH-1:0] divisor_a;
  logic             gnt_s;
  logic             gnt_a;
  logic             done_s;
  logic             done_a;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             div_en;
  logic             div_select;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic             div_ready;
  logic [WIDTH-1:0] div_result;

  modport master (
    input  req_s, dividend_s, divisor_s, req_a, dividend_a, divisor_a,
    input  div_busy, div_ready, div_result,
    output gnt_s, gnt_a, done_s, done_a, result, err,
    output div_en, div_select, div_dividend, div_divisor
  );

  modport slave (
    output req_s, dividend_s, divisor_s, req_a, dividend_a, divisor_a,
    output div_busy, div_ready, div_result,
    input  gnt_s, gnt_a, done_s, done_a, result, err,
    input  div_en, div_select, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between requesters S and A.
// Optional WAIT timeout abort is enabled by defining DIV_TIMEOUT_EN.
module div_arbiter #(
  parameter int unsigned WIDTH = 12
`ifdef DIV_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic          clock,
  input logic          reset,
  div_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e state_q;
  logic   owner_q;  // 0 = S, 1 = A
  logic   last_q;   // requester served most recently
  logic   pick;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
`endif

  always_comb begin
    pick = 1'b0;
    if (bus.req_s && bus.req_a) begin
      pick = ~last_q;
    end else begin
      pick = bus.req_a;
    end
    sel_dividend = pick ? bus.dividend_a : bus.dividend_s;
    sel_divisor  = pick ? bus.divisor_a  : bus.divisor_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      owner_q          <= 1'b0;
      last_q           <= 1'b1;  // makes S win the first tie
      bus.gnt_s        <= 1'b0;
      bus.gnt_a        <= 1'b0;
      bus.done_s       <= 1'b0;
      bus.done_a       <= 1'b0;
      bus.result       <= '0;
      bus.err          <= 1'b0;
      bus.div_en       <= 1'b0;
      bus.div_select   <= 1'b0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
`ifdef DIV_TIMEOUT_EN
      cnt_q            <= '0;
`endif
    end else begin
      bus.gnt_s  <= 1'b0;
      bus.gnt_a  <= 1'b0;
      bus.done_s <= 1'b0;
      bus.done_a <= 1'b0;
      bus.err    <= 1'b0;
      bus.div_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if ((bus.req_s || bus.req_a) && !bus.div_busy) begin
            owner_q          <= pick;
            bus.div_select   <= pick;
            bus.div_dividend <= sel_dividend;
            bus.div_divisor  <= sel_divisor;
            bus.gnt_s        <= ~pick;
            bus.gnt_a        <= pick;
            if (sel_divisor == '0) begin
              // Divide-by-zero never reaches the divider.
              bus.result <= '1;
              bus.done_s <= ~pick;
              bus.done_a <= pick;
              state_q    <= StDone;
            end else begin
              bus.div_en <= 1'b1;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
`ifdef DIV_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (bus.div_ready) begin
            bus.result <= bus.div_result;
            bus.done_s <= ~owner_q;
            bus.done_a <= owner_q;
            state_q    <= StDone;
`ifdef DIV_TIMEOUT_EN
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            bus.result <= '1;
            bus.done_s <= ~owner_q;
            bus.done_a <= owner_q;
            bus.err    <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        StDone: begin
          last_q  <= owner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider model.
// Define DIV_TIMEOUT_EN for both RTL and bench to exercise the timeout abort.
module tb_div_arbiter;
  localparam int unsigned WIDTH = 12;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  div_arbiter_if #(.WIDTH(WIDTH)) bus ();
  div_arbiter #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Divider model: ready rises div_lat cycles after the cycle where div_en is high.
  int   div_lat = 8;
  bit   div_never = 1'b0;
  bit   force_busy = 1'b0;
  bit   model_clear = 1'b0;
  logic active = 1'b0;
  int   tick = 0;
  logic [WIDTH-1:0] quot = '0;

  always @(posedge clock) begin
    if (model_clear) begin
      active <= 1'b0;
    end else if (bus.div_en) begin
      active <= 1'b1;
      tick   <= 1;
      quot   <= (bus.div_divisor == '0) ? ALL_ONES : bus.div_dividend / bus.div_divisor;
    end else if (active) begin
      if (bus.div_ready) active <= 1'b0;
      else tick <= tick + 1;
    end
  end

  assign bus.div_ready  = active && (tick == div_lat) && !div_never;
  assign bus.div_busy   = active | force_busy;
  assign bus.div_result = quot;

  function automatic logic [WIDTH-1:0] exp_quot(input logic [WIDTH-1:0] n,
                                                 input logic [WIDTH-1:0] d);
    return (d == '0) ? ALL_ONES : n / d;
  endfunction

  function automatic logic [WIDTH-1:0] rand_divisor();
    return ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom_range(1, 4095));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear = 1'b1;
    bus.req_s = 1'b0;
    bus.req_a = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_clear = 1'b0;
  endtask

  function automatic logic [3*WIDTH+6:0] all_outputs();
    return {bus.gnt_s, bus.gnt_a, bus.done_s, bus.done_a, bus.err, bus.div_en,
            bus.div_select, bus.result, bus.div_dividend, bus.div_divisor};
  endfunction

  task automatic test_reset();
    bus.dividend_s = '0; bus.divisor_s = '0; bus.dividend_a = '0; bus.divisor_a = '0;
    apply_reset();
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0", all_outputs());
    end
    step();
    checks++;
    if (bus.gnt_s !== 1'b0 || bus.div_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got gnt_s=%0b div_en=%0b exp 0 0", bus.gnt_s, bus.div_en);
    end
  endtask

  task automatic test_single();
    int c = 1;
    apply_reset();
    bus.req_s = 1'b1; bus.dividend_s = 12'd1200; bus.divisor_s = 12'd10;
    step();
    checks++;
    if (bus.gnt_s !== 1'b1 || bus.div_en !== 1'b1 || bus.div_select !== 1'b0 ||
        bus.div_divisor !== 12'd10 || bus.div_dividend !== 12'd1200) begin
      failures++;
      $display("FAIL single_issue got gnt_s=%0b en=%0b sel=%0b a=%0d b=%0d exp 1 1 0 1200 10",
               bus.gnt_s, bus.div_en, bus.div_select, bus.div_dividend, bus.div_divisor);
    end
    while (!bus.done_s && c < 40) begin
      step();
      c++;
    end
    checks++;
    if (c !== 10 || bus.done_s !== 1'b1 || bus.result !== 12'd120 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL single_done got cycle=%0d done=%0b result=%0d err=%0b exp 10 1 120 0",
               c, bus.done_s, bus.result, bus.err);
    end
    bus.req_s = 1'b0;
    step();
    checks++;
    if (bus.done_s !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse got=%0b exp=0", bus.done_s);
    end
  endtask

  task automatic test_alternation();
    apply_reset();
    bus.req_s = 1'b1; bus.dividend_s = 12'd600; bus.divisor_s = 12'd6;
    bus.req_a = 1'b1; bus.dividend_a = 12'd90;  bus.divisor_a = 12'd9;
    for (int op = 0; op < 4; op++) begin
      bit exp_a = (op % 2) == 1;
      logic [WIDTH-1:0] exp_r = exp_a ? 12'd10 : 12'd100;
      int n = 0;
      while (!(bus.done_s || bus.done_a) && n < 40) begin
        step();
        n++;
      end
      checks++;
      if (bus.done_a !== exp_a || bus.done_s !== !exp_a || bus.result !== exp_r ||
          bus.div_select !== exp_a) begin
        failures++;
        $display("FAIL alternation op=%0d got done_s=%0b done_a=%0b sel=%0b result=%0d exp a=%0b r=%0d",
                 op, bus.done_s, bus.done_a, bus.div_select, bus.result, exp_a, exp_r);
      end
      if (op < 3) step();  // leave DONE with both requests still pending
    end
    bus.req_s = 1'b0;
    bus.req_a = 1'b0;
    step();
  endtask

  task automatic test_div_zero();
    apply_reset();
    bus.req_a = 1'b1; bus.dividend_a = 12'd77; bus.divisor_a = 12'd0;
    step();
    checks++;
    if (bus.gnt_a !== 1'b1 || bus.done_a !== 1'b1 || bus.div_en !== 1'b0 ||
        bus.result !== ALL_ONES || bus.err !== 1'b0 || bus.done_s !== 1'b0) begin
      failures++;
      $display("FAIL div_zero got gnt_a=%0b done_a=%0b en=%0b result=%0h err=%0b exp 1 1 0 fff 0",
               bus.gnt_a, bus.done_a, bus.div_en, bus.result, bus.err);
    end
    bus.req_a = 1'b0;
    step();
    checks++;
    if (bus.done_a !== 1'b0 || bus.div_en !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_after got done_a=%0b en=%0b exp 0 0", bus.done_a, bus.div_en);
    end
  endtask

  task automatic test_reset_mid_op();
    bit any_done = 1'b0;
    apply_reset();
    bus.req_s = 1'b1; bus.dividend_s = 12'd500; bus.divisor_s = 12'd5;
    repeat (4) step();
    reset = 1'b1;
    bus.req_s = 1'b0;
    step();
    checks++;
    if (all_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_op got=%0h exp=0", all_outputs());
    end
    reset = 1'b0;
    repeat (15) begin
      step();
      if (bus.done_s || bus.done_a || bus.err) any_done = 1'b1;
    end
    checks++;
    if (any_done !== 1'b0) begin
      failures++;
      $display("FAIL late_ready_ignored got done=%0b exp=0", any_done);
    end
  endtask

  task automatic test_busy();
    bit early = 1'b0;
    int n = 0;
    apply_reset();
    force_busy = 1'b1;
    bus.req_s = 1'b1; bus.dividend_s = 12'd300; bus.divisor_s = 12'd3;
    repeat (5) begin
      step();
      if (bus.gnt_s || bus.div_en) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL busy_hold got grant=%0b exp=0", early);
    end
    force_busy = 1'b0;
    step();
    checks++;
    if (bus.gnt_s !== 1'b1) begin
      failures++;
      $display("FAIL busy_release got gnt_s=%0b exp=1", bus.gnt_s);
    end
    while (!bus.done_s && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (bus.done_s !== 1'b1 || bus.result !== 12'd100) begin
      failures++;
      $display("FAIL busy_result got done=%0b result=%0d exp 1 100", bus.done_s, bus.result);
    end
    bus.req_s = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit ps = 1'b0, pa = 1'b0, last = 1'b1;
    logic [WIDTH-1:0] es_n = '0, es_d = '0, ea_n = '0, ea_d = '0;
    apply_reset();
    for (int it = 0; it < 24; it++) begin
      bit win, got_done, gnt_ok;
      logic [WIDTH-1:0] exp_r;
      int n = 0;
      div_lat = $urandom_range(1, 10);
      if (!ps && $urandom_range(0, 2) != 0) begin
        ps = 1'b1; es_n = WIDTH'($urandom); es_d = rand_divisor();
      end
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; ea_n = WIDTH'($urandom); ea_d = rand_divisor();
      end
      if (!ps && !pa) begin
        ps = 1'b1; es_n = WIDTH'($urandom); es_d = rand_divisor();
      end
      bus.req_s = ps; bus.dividend_s = es_n; bus.divisor_s = es_d;
      bus.req_a = pa; bus.dividend_a = ea_n; bus.divisor_a = ea_d;
      win = (ps && pa) ? !last : pa;
      exp_r = win ? exp_quot(ea_n, ea_d) : exp_quot(es_n, es_d);
      got_done = 1'b0;
      gnt_ok = 1'b0;
      while (!got_done && n < 40) begin
        step();
        n++;
        if (bus.gnt_s || bus.gnt_a) begin
          if (bus.gnt_a == win && bus.gnt_s == !win) gnt_ok = 1'b1;
          // Winner's operands change after grant; the op must not notice.
          if (win) begin bus.dividend_a = WIDTH'($urandom); bus.divisor_a = rand_divisor(); end
          else begin bus.dividend_s = WIDTH'($urandom); bus.divisor_s = rand_divisor(); end
        end
        if (bus.done_s || bus.done_a) got_done = 1'b1;
      end
      checks++;
      if (!got_done || !gnt_ok || bus.done_a !== win || bus.done_s !== !win ||
          bus.result !== exp_r) begin
        failures++;
        $display("FAIL random it=%0d got done_s=%0b done_a=%0b gnt_ok=%0b result=%0h exp owner=%0b result=%0h",
                 it, bus.done_s, bus.done_a, gnt_ok, bus.result, win, exp_r);
      end
      last = win;
      if (win) begin pa = 1'b0; bus.req_a = 1'b0; end
      else begin ps = 1'b0; bus.req_s = 1'b0; end
    end
    bus.req_s = 1'b0;
    bus.req_a = 1'b0;
    div_lat = 8;
    step();
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    div_never = 1'b1;
    bus.req_s = 1'b1; bus.dividend_s = 12'd100; bus.divisor_s = 12'd4;
`ifdef DIV_TIMEOUT_EN
    begin
      int c = 0;
      while (!bus.done_s && c < 300) begin
        step();
        c++;
      end
      checks++;
      if (c !== int'(TIMEOUT_CYCLES) + 2 || bus.done_s !== 1'b1 || bus.err !== 1'b1 ||
          bus.result !== ALL_ONES) begin
        failures++;
        $display("FAIL timeout got cycle=%0d done=%0b err=%0b result=%0h exp %0d 1 1 fff",
                 c, bus.done_s, bus.err, bus.result, TIMEOUT_CYCLES + 2);
      end
    end
`else
    begin
      bit any = 1'b0;
      repeat (1000) begin
        step();
        if (bus.done_s || bus.done_a || bus.err) any = 1'b1;
      end
      checks++;
      if (any !== 1'b0) begin
        failures++;
        $display("FAIL no_timeout got done_or_err=%0b exp=0", any);
      end
    end
`endif
    div_never = 1'b0;
    apply_reset();
  endtask

  initial begin
    bus.req_s = 1'b0;
    bus.req_a = 1'b0;
    test_reset();
    test_single();
    test_alternation();
    test_div_zero();
    test_reset_mid_op();
    test_busy();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
